// File: rtl/lz_share_arb.sv
// Shares one combinational 48-bit LZC between the FP adder (A) and scalar LZ path (B); 2-cycle latency, no backpressure.
// Optional LZ_SHARE_ZERO_FLAG_EN adds res_zero, an all-zero operand flag aligned with the result pulse.
module lz_share_arb #(
  parameter int STARVE_LIM = 4,
  parameter int W          = 48
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         a_valid,
  input  logic [W-1:0] a_data,
  output logic         a_ready,
  input  logic         b_valid,
  input  logic [W-1:0] b_data,
  output logic         b_ready,
  output logic [W-1:0] lz_data,
  input  logic [6:0]   lz_cnt,
  output logic [6:0]   res_cnt,
  output logic         res_valid_a,
  output logic         res_valid_b,
  output logic         busy
`ifdef LZ_SHARE_ZERO_FLAG_EN
  ,
  output logic         res_zero
`endif
);

  localparam logic [3:0] LIM_C = 4'(STARVE_LIM);

  logic [3:0]   starve_q, starve_d;
  logic [W-1:0] lz_data_q, lz_data_d;
  logic         s1_valid_q, s1_valid_d;
  logic         s1_tag_q, s1_tag_d;
  logic [6:0]   res_cnt_q, res_cnt_d;
  logic         res_va_q, res_va_d;
  logic         res_vb_q, res_vb_d;
  logic         force_b, grant_a, grant_b;

  // Grants are masked by reset so neither requester sees an accept while held in reset.
  always_comb begin
    force_b = b_valid && (starve_q == LIM_C);
    grant_a = rst_n && a_valid && !force_b;
    grant_b = rst_n && b_valid && !grant_a;
  end

  always_comb begin
    starve_d   = starve_q;
    lz_data_d  = lz_data_q;
    s1_valid_d = grant_a || grant_b;
    s1_tag_d   = grant_b;
    res_cnt_d  = res_cnt_q;
    res_va_d   = s1_valid_q && !s1_tag_q;
    res_vb_d   = s1_valid_q && s1_tag_q;
    if (!b_valid || grant_b) begin
      starve_d = 4'd0;
    end else if (grant_a && (starve_q != LIM_C)) begin
      starve_d = starve_q + 4'd1;
    end
    if (grant_b) begin
      lz_data_d = b_data;
    end else if (grant_a) begin
      lz_data_d = a_data;
    end
    if (s1_valid_q) begin
      res_cnt_d = lz_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q   <= 4'd0;
      lz_data_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_tag_q   <= 1'b0;
      res_cnt_q  <= 7'd0;
      res_va_q   <= 1'b0;
      res_vb_q   <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      lz_data_q  <= lz_data_d;
      s1_valid_q <= s1_valid_d;
      s1_tag_q   <= s1_tag_d;
      res_cnt_q  <= res_cnt_d;
      res_va_q   <= res_va_d;
      res_vb_q   <= res_vb_d;
    end
  end

`ifdef LZ_SHARE_ZERO_FLAG_EN
  logic s1_zero_q, s1_zero_d;
  logic res_zero_q, res_zero_d;

  always_comb begin
    s1_zero_d  = grant_b ? (b_data == '0) : (a_data == '0);
    res_zero_d = s1_valid_q && s1_zero_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_zero_q  <= 1'b0;
      res_zero_q <= 1'b0;
    end else begin
      s1_zero_q  <= s1_zero_d;
      res_zero_q <= res_zero_d;
    end
  end

  assign res_zero = res_zero_q;
`endif

  assign a_ready     = grant_a;
  assign b_ready     = grant_b;
  assign lz_data     = lz_data_q;
  assign res_cnt     = res_cnt_q;
  assign res_valid_a = res_va_q;
  assign res_valid_b = res_vb_q;
  assign busy        = s1_valid_q || res_va_q || res_vb_q;

endmodule
